// File: rtl/ram_sync_pkg.sv
// ============================================================================
//  Module   : ram_sync_pkg
//  Brief    : Shared state encoding and control-level constants for ram_sync.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ram_sync_pkg;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_t;

  localparam logic c_CHIP_ENABLE  = 1'b1;
  localparam logic c_READ_ENABLE  = 1'b1;
  localparam logic c_WRITE_ENABLE = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_array.sv
// ============================================================================
//  Module   : ram_array
//  Brief    : Word storage with per-byte write lanes and a registered,
//             read-first read port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ram_array #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int NB     = DATA_W / 8,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [NB-1:0]     wr_sel,
  input  logic              rd_en,
  input  logic [IW-1:0]     rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_sel[k]) begin
          r_mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
    // Non-blocking read of the same array gives the pre-write word.
    if (rd_en) begin
      r_rd_data <= r_mem[rd_idx];
    end
  end

  assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/ram_sync.sv
// ============================================================================
//  Module   : ram_sync
//  Brief    : Synchronous byte-writable data RAM with clear-on-reset sequencer,
//             registered reads with valid strobe. Define RAM_FWD_EN for
//             write-first same-index forwarding (default is read-first).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ram_sync
  import ram_sync_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  parameter  int ADDR_W = 32,
  localparam int NB     = DATA_W / 8,
  localparam int IW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              re,
  input  logic              we,
  input  logic [ADDR_W-1:0] read_addr,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic [NB-1:0]     write_sel,
  output logic              ready
);

  ram_state_t        r_state;
  logic [IW-1:0]     r_cnt;
  logic              r_ready;
  logic              r_valid;

  logic [IW-1:0]     w_ridx;
  logic [IW-1:0]     w_widx;
  logic              w_run;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_arr_we;
  logic [IW-1:0]     w_arr_widx;
  logic [DATA_W-1:0] w_arr_wdata;
  logic [NB-1:0]     w_arr_wsel;
  logic [DATA_W-1:0] w_arr_rdata;
  logic [DATA_W-1:0] w_merged;
  logic              w_unused_addr;

  assign w_ridx        = read_addr[IW+1:2];
  assign w_widx        = write_addr[IW+1:2];
  assign w_unused_addr = ^{read_addr, write_addr};

  assign w_run    = (r_state == ST_RUN);
  assign w_rd_acc = !rst && w_run && (ce == c_CHIP_ENABLE) && (re == c_READ_ENABLE);
  assign w_wr_acc = !rst && w_run && (ce == c_CHIP_ENABLE) && (we == c_WRITE_ENABLE);

  // While clearing, the sequencer owns the write port with full-word zero writes.
  assign w_arr_we    = !rst && (!w_run || w_wr_acc);
  assign w_arr_widx  = w_run ? w_widx : r_cnt;
  assign w_arr_wdata = w_run ? write_data : '0;
  assign w_arr_wsel  = w_run ? write_sel : '1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAR;
      r_cnt   <= '0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_valid <= 1'b0;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == IW'(DEPTH - 1)) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          r_valid <= w_rd_acc;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_cnt   <= '0;
          r_ready <= 1'b0;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  ram_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk     (clk),
    .wr_en   (w_arr_we),
    .wr_idx  (w_arr_widx),
    .wr_data (w_arr_wdata),
    .wr_sel  (w_arr_wsel),
    .rd_en   (w_rd_acc),
    .rd_idx  (w_ridx),
    .rd_data (w_arr_rdata)
  );

`ifdef RAM_FWD_EN
  logic [NB-1:0]     r_fwd_sel;
  logic [DATA_W-1:0] r_fwd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_sel  <= '0;
      r_fwd_data <= '0;
    end else begin
      r_fwd_sel  <= (w_rd_acc && w_wr_acc && (w_ridx == w_widx)) ? write_sel : '0;
      r_fwd_data <= write_data;
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_fwd_lane
    assign w_merged[8*k +: 8] = r_fwd_sel[k] ? r_fwd_data[8*k +: 8] : w_arr_rdata[8*k +: 8];
  end
`else
  assign w_merged = w_arr_rdata;
`endif

  // Array read register holds stale data between reads; mask to zero.
  assign read_data  = r_valid ? w_merged : '0;
  assign read_valid = r_valid;
  assign ready      = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_ram_sync.sv
// ============================================================================
//  Module   : tb_ram_sync
//  Brief    : Self-checking bench for ram_sync (DEPTH=1024, DATA_W=32).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_sync;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce = 1'b0, re = 1'b0, we = 1'b0;
  logic [31:0] read_addr = '0, write_addr = '0, write_data = '0;
  logic [3:0]  write_sel = '0;
  logic [31:0] read_data;
  logic        read_valid;
  logic        ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [1024];
  logic [31:0] exp_q [$];

  ram_sync #(.DATA_W(32), .DEPTH(1024), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .re         (re),
    .we         (we),
    .read_addr  (read_addr),
    .read_data  (read_data),
    .read_valid (read_valid),
    .write_addr (write_addr),
    .write_data (write_data),
    .write_sel  (write_sel),
    .ready      (ready)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ce = 1'b0; re = 1'b0; we = 1'b0; write_sel = '0;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    for (int k = 0; k < 4; k++)
      if (sel[k]) model[addr[11:2]][8*k +: 8] = data[8*k +: 8];
  endtask

  task automatic model_clear();
    for (int i = 0; i < 1024; i++) model[i] = '0;
  endtask

  // Counts falling edges after rst release until ready, with re held high.
  task automatic run_clear(output int n, output bit saw_valid);
    n = 0; saw_valid = 0;
    ce = 1'b1; re = 1'b1;
    while (n < 2000) begin
      read_addr = $urandom;
      @(negedge clk);
      n++;
      if (read_valid) saw_valid = 1;
      if (ready) break;
    end
    idle();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; write_addr = addr; write_data = data; write_sel = sel;
    model_write(addr, data, sel);
    @(negedge clk);
    idle();
  endtask

  task automatic do_read(input string name, input logic [31:0] addr);
    logic [31:0] exp;
    @(negedge clk);
    ce = 1'b1; re = 1'b1; read_addr = addr;
    exp_q.push_back(model[addr[11:2]]);
    @(negedge clk);
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (read_valid !== 1'b1 || read_data !== exp) begin
      failures++;
      $display("FAIL %s: valid=%b data=%h, required valid=1 data=%h", name, read_valid, read_data, exp);
    end
  endtask

  task automatic test_reset();
    int  n;
    bit  sv;
    @(negedge clk);
    rst = 1'b1; idle(); model_clear();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ready !== 1'b0 || read_valid !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_values: ready=%b valid=%b data=%h, required 0 0 0", ready, read_valid, read_data);
    end
    rst = 1'b0;
    run_clear(n, sv);
    checks++;
    if (n !== 1024) begin
      failures++;
      $display("FAIL clear_duration: cycles=%0d, required 1024", n);
    end
    checks++;
    if (sv !== 1'b0) begin
      failures++;
      $display("FAIL read_during_clear: valid seen=%b, required 0", sv);
    end
  endtask

  task automatic test_cleared_read();
    do_read("cleared_0ffc", 32'h0000_0FFC);
    do_read("cleared_0000", 32'h0000_0000);
  endtask

  task automatic test_byte_write();
    do_write(32'h10, 32'hDEAD_BEEF, 4'b1111);
    do_write(32'h10, 32'h0000_0011, 4'b0001);
    do_write(32'h10, 32'hFFFF_FFFF, 4'b0000);
    do_read("byte_merge", 32'h10);
    checks++;
    if (model[4] !== 32'hDEAD_BE11) begin
      failures++;
      $display("FAIL byte_model: model=%h, required DEADBE11", model[4]);
    end
    @(negedge clk);
    checks++;
    if (read_valid !== 1'b0 || read_data !== 32'h0) begin
      failures++;
      $display("FAIL valid_one_cycle: valid=%b data=%h, required 0 0", read_valid, read_data);
    end
  endtask

  task automatic test_same_index();
    logic [31:0] exp;
    @(negedge clk);
    ce = 1'b1; re = 1'b1; we = 1'b1;
    read_addr = 32'h10; write_addr = 32'h10; write_data = 32'h1234_5678; write_sel = 4'b1100;
`ifdef RAM_FWD_EN
    exp_q.push_back(32'h1234_BE11);
`else
    exp_q.push_back(32'hDEAD_BE11);
`endif
    model_write(32'h10, 32'h1234_5678, 4'b1100);
    @(negedge clk);
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (read_valid !== 1'b1 || read_data !== exp) begin
      failures++;
      $display("FAIL same_index: valid=%b data=%h, required 1 %h", read_valid, read_data, exp);
    end
    do_read("after_same_index", 32'h10);
    // Different indices in one cycle are independent.
    @(negedge clk);
    ce = 1'b1; re = 1'b1; we = 1'b1;
    read_addr = 32'h10; write_addr = 32'h14; write_data = 32'hCAFE_0001; write_sel = 4'b1111;
    exp_q.push_back(model[4]);
    model_write(32'h14, 32'hCAFE_0001, 4'b1111);
    @(negedge clk);
    idle();
    exp = exp_q.pop_front();
    checks++;
    if (read_valid !== 1'b1 || read_data !== exp) begin
      failures++;
      $display("FAIL diff_index: valid=%b data=%h, required 1 %h", read_valid, read_data, exp);
    end
    do_read("diff_index_write", 32'h14);
  endtask

  task automatic test_wrap();
    do_write(32'h0000_1000, 32'hA5A5_A5A5, 4'b1111);
    checks++;
    if (model[0] !== 32'hA5A5_A5A5) begin
      failures++;
      $display("FAIL wrap_model: model=%h, required A5A5A5A5", model[0]);
    end
    do_read("wrap_addr0", 32'h0000_0000);
    do_read("wrap_low_bits", 32'hFFFF_F003);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    int run = 0;
    for (int i = 0; i < 10; i++)
      do_write(32'(4 * i), 32'h1000_0000 + 32'(i) * 32'h0011_1111, 4'b1111);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i > 0) begin
        if (read_valid === 1'b1) run++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        checks++;
        if (read_data !== exp) begin
          failures++;
          $display("FAIL b2b_data[%0d]: data=%h, required %h", i - 1, read_data, exp);
        end
      end
      if (i < 10) begin
        ce = 1'b1; re = 1'b1; read_addr = 32'(4 * i);
        exp_q.push_back(model[i]);
      end else begin
        idle();
      end
    end
    @(negedge clk);
    checks++;
    if (run !== 10 || read_valid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_valid_run: run=%0d trailing_valid=%b, required 10 0", run, read_valid);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    bit sv;
    @(negedge clk);
    rst = 1'b1; idle();
    @(negedge clk);
    rst = 1'b0;
    repeat (500) @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_clear_ready: ready=%b, required 0", ready);
    end
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    run_clear(n, sv);
    checks++;
    if (n !== 1024) begin
      failures++;
      $display("FAIL restart_duration: cycles=%0d, required 1024", n);
    end
    do_read("cleared_after_restart_10", 32'h10);
    do_read("cleared_after_restart_0", 32'h0);
    do_read("cleared_after_restart_14", 32'h14);
  endtask

  initial begin
    test_reset();
    test_cleared_read();
    test_byte_write();
    test_same_index();
    test_wrap();
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ram_sync.md
# ram_sync

Parametrised synchronous data RAM, the successor to the instruction/data RAM with byte-write. It adds registered reads with a valid strobe, configurable width and depth, a built-in clear-on-reset sequencer, and optional write-to-read forwarding. It sits behind the MEM stage or the instruction-fetch port. All accesses occur on the rising edge of a single clock.

## Interface
Parameters:
- DATA_W, 32: word width; must be a multiple of 8; byte lanes NB = DATA_W/8.
- DEPTH, 1024: number of words; must be a power of two; index width IW = log2(DEPTH).
- ADDR_W, 32: byte-address width; must satisfy ADDR_W ≥ IW+2.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset; synchronous, active-high.
- ce  in  1  chip enable (`ChipEnable).
- re  in  1  read enable (`ReadEnable).
- we  in  1  write enable (`WriteEnable).
- read_addr  in  ADDR_W  byte address; word index = read_addr[IW+1:2].
- read_data  out  DATA_W  registered read data.
- read_valid  out  1  high for one cycle when read_data carries an accepted read.
- write_addr  in  ADDR_W  byte address; word index = write_addr[IW+1:2].
- write_data  in  DATA_W  write data.
- write_sel  in  NB  per-byte write enable; bit k covers bits [8k+7:8k].
- ready  out  1  high once the clear sequence is complete; low while clearing.

## Operation
- States: CLEAR, RUN.
- rst=1 at posedge: state←CLEAR, clear counter←0, ready←0, read_valid←0, read_data←0.
- CLEAR: each cycle writes 0 to mem[counter] and increments the counter.
  - When counter==DEPTH-1 is written, state←RUN and ready←1 at that same edge.
  - ce/re/we are ignored; read_valid stays 0.
- RUN, write: when ce&we at posedge, for each k with write_sel[k]=1, byte k of mem[widx] ← write_data byte k. Other bytes are unchanged. write_sel=0 is a no-op.
- RUN, read: when ce&re at posedge, read_data←mem[ridx] and read_valid←1. Otherwise read_valid←0 and read_data←0.
- Addressing: address bits [1:0] and bits above IW+1 are ignored. Addresses wrap modulo DEPTH words.
- Read and write to the same index in one cycle: the result depends on RAM_FWD_EN (see Configuration). Different indices proceed independently.
- rst asserted mid-CLEAR or mid-RUN: the sequence restarts from index 0. Any read or write in that cycle is dropped.

## Timing
- Read latency is 1 cycle: request at edge N gives read_valid and read_data valid after edge N, and they are sampled at edge N+1.
- Back-to-back reads every cycle are supported; read_valid stays high.
- Write is visible to a read issued at the following edge.
- Clear duration: ready rises after the DEPTH-th posedge following rst deassertion. For DEPTH=1024, the first accepted access is at edge 1025 after the reset edge.
- Reset values: read_data=0, read_valid=0, ready=0.

## Configuration
- RAM_FWD_EN defined: write-first behaviour.
  - A same-index read/write returns the merged word: bytes with write_sel=1 come from write_data, the rest from mem.
- RAM_FWD_EN undefined: read-first behaviour.
  - A same-index read/write returns the pre-write word.
  - This configuration maps onto plain block RAM.

## Structure
- define.v holds:
  - `ChipEnable, `ReadEnable, `WriteEnable (existing).
  - New `RamStClear and `RamStRun state encodings.
  - `ZeroWord.
- Sub-module ram_array: storage with byte-lane write and a registered read port, without forwarding.
- ram_sync contains:
  - the clear FSM and counter;
  - a mux that steers either the clear write or the user write into ram_array;
  - the forwarding merge logic;
  - read_valid generation.

## Test plan
- Reset with DEPTH=1024:
  - ready=0 for 1024 cycles, then ready=1.
  - A read of any index before ready gives read_valid=0.
  - After ready, reading addr 0x0FFC returns 0.
- Write 0xDEADBEEF to addr 0x10 with write_sel=4'b1111, then write 0x00000011 with write_sel=4'b0001. A read of 0x10 returns 0xDEADBE11, with read_valid high for exactly one cycle.
- Same-cycle write of 0x12345678 with write_sel=4'b1100 and read of addr 0x10 (holding 0xDEADBE11):
  - returns 0x1234BE11 with RAM_FWD_EN defined;
  - returns 0xDEADBE11 without it.
- Wrap-around: write 0xA5A5A5A5 to addr 0x1000 (DEPTH=1024). A read of addr 0x0 returns 0xA5A5A5A5.
- rst pulsed at clear counter=500: the counter restarts at 0, ready rises 1024 cycles later, and previously written data reads back as 0.
- Ten back-to-back reads of addresses 0x0..0x24: read_valid is high for 10 consecutive cycles, and the data matches in order.
